new_means_controller: RTL and testbench
=======================================

# new_means_controller

Sequencer for the new-means calculation block: on a `start` pulse it walks every centroid index, drives `cent_cnt`/`divider_en` into the divider datapath, waits the fixed divider latency, and writes each resulting `new_centroid` into the centroid memory. Centroids whose count is zero (`divide_by_0`) are skipped so their old value is retained. It sits between the top-level k-means controller (start/done) and the divider plus centroid RAM.

## Interface

**Parameters**
- `centroid_num`, 8: centroids per pass; `cent_cnt` walks 0..centroid_num-1.
- `div_latency`, 2: cycles from `cent_cnt`/`divider_en` change to valid `new_centroid`/`divide_by_0`. Must be ≥1.
- `addrWidth`, 8: centroid memory address width.
- `dataWidth`, 91: centroid word width (7 coordinates × 13 bits).
- `cent_base_addr`, 0: memory address of centroid 0. Centroid i is at `cent_base_addr+i`.

**Ports**
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a pass; sampled only in IDLE.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at end of pass.
- `cent_cnt` out 3: centroid index to the divider.
- `divider_en` out 1: divider enable.
- `divide_by_0` in 1: divider reports zero count for the current index.
- `new_centroid` in dataWidth: divider result.
- `mem_we` out 1: centroid memory write strobe.
- `mem_re` out 1: centroid memory read strobe (only with the macro).
- `mem_addr` out addrWidth: shared read/write address.
- `mem_wdata` out dataWidth: write data.
- `mem_rdata` in dataWidth: read data, valid one cycle after `mem_re`.
- `empty_cnt` out 4: number of centroids skipped for `divide_by_0` in the last pass.
- `converged` out 1: last pass changed no centroid (only with the macro).

## Operation

- FSM states: IDLE, CALC, WRITE, DONE.
- IDLE: if `start`=1, clear `empty_cnt`/`converged` flags, set idx=0, and go to CALC. Otherwise stay in IDLE.
- CALC: drive `cent_cnt`=idx and `divider_en`=1. A wait counter runs 0..div_latency, so CALC lasts div_latency+1 cycles. On the cycle the counter equals div_latency, register `new_centroid` and `divide_by_0`, then go to WRITE.
- WRITE: `divider_en`=0 and `mem_addr`=cent_base_addr+idx.
  - If the sampled `divide_by_0`=0: `mem_we`=1 and `mem_wdata`= the sampled centroid.
  - If it was 1: `mem_we`=0 and `empty_cnt` increments.
  - Then: if idx=centroid_num-1, go to DONE; else idx+1 and go to CALC.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in CALC, WRITE and DONE. There is no queuing.
- `empty_cnt` and `converged` hold their values from `done` until the next accepted `start`.
- `empty_cnt` saturates at 15.

## Timing

- All outputs are registered.
- Reset value of every output is 0: `busy`, `done`, `cent_cnt`, `divider_en`, `mem_we`, `mem_re`, `mem_addr`, `mem_wdata`, `empty_cnt`, `converged`.
- Let T be the cycle in which `start` is sampled in IDLE, L = div_latency, N = centroid_num.
  - CALC for idx i begins at T+1+i·(L+2).
  - WRITE for idx i occurs at T+1+i·(L+2)+L+1.
  - `done` is asserted at T+1+N·(L+2). With defaults: writes at T+4, T+8, … T+32; `done` at T+33.
- `busy` is 1 from T+1 through the `done` cycle inclusive.
- A `start` in the `done` cycle is ignored. The earliest new accept is the cycle after `done`.
- `rst` mid-pass: FSM goes to IDLE and all outputs clear asynchronously. No further write is issued, and a partially completed pass is not resumed.
- `divide_by_0` and `new_centroid` are sampled only on the last CALC cycle. Values on other cycles are don't-care.

## Configuration

- Macro: `NEW_MEANS_CONVERGENCE_CHECK_EN`.
- **Defined:**
  - In the first CALC cycle of each idx, `mem_re`=1 and `mem_addr`=cent_base_addr+idx.
  - `mem_rdata` is captured on the next cycle.
  - In WRITE, a non-skipped centroid whose new value differs from the captured old value clears an internal "unchanged" flag. That flag is set on `start` accept.
  - `converged` is loaded from the flag in the DONE cycle. Skipped centroids count as unchanged.
- **Not defined:** `mem_re` and `converged` are tied to 0, and no read logic is present.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately. After release, outputs stay 0 with no `start`.
- **Full pass:** defaults, all `divide_by_0`=0, divider returns idx-dependent data → `mem_we` at T+4, T+8 … T+32 with addresses 0..7 and matching data; `done` at T+33; `empty_cnt`=0.
- **Empty clusters:** `divide_by_0`=1 for idx 3 and 5 → no write to addresses 3 and 5, six writes total, `empty_cnt`=2 at `done`.
- **Start handling:** `start` pulse at T+10 and in the `done` cycle → both ignored. A `start` one cycle after `done` begins a new pass from idx 0, and `empty_cnt` clears.
- **Reset mid-pass:** `rst` during CALC of idx 4 → no write to address 4 or above, `busy`=0. The next `start` writes addresses 0..7 again.
- **Convergence (macro on):**
  - `mem_rdata` equals `new_centroid` for every idx → `converged`=1.
  - idx 6 differs → `converged`=0.
  - Macro off → `mem_re` never 1 and `converged`=0.

Source files
------------

// File: rtl/new_means_controller.sv
// new_means_controller
//   Sequencer for the new-means step of k-means. A start pulse walks every
//   centroid index through the divider, waits the divider latency, and writes
//   each new centroid back to centroid memory. Indices whose divider reports a
//   zero count are skipped so the old centroid is retained; those skips are
//   counted in empty_cnt.
//
// Optional feature (compile-time macro): NEW_MEANS_CONVERGENCE_CHECK_EN
//   When defined, the old centroid is read before each write and compared
//   with the new value; converged reports a pass that changed no centroid.
//   When undefined, mem_re and converged are tied low and no read logic exists.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle pass request, accepted only in IDLE
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   cent_cnt, divider_en  index and enable driven into the divider
//   divide_by_0, new_centroid  divider outputs for the current index
//   mem_we, mem_re, mem_addr, mem_wdata, mem_rdata  centroid memory port
//   empty_cnt           centroids skipped in the last pass (saturates at 15)
//   converged           last pass changed no centroid

module new_means_controller #(
    parameter int unsigned centroid_num   = 8,
    parameter int unsigned div_latency    = 2,
    parameter int unsigned addrWidth      = 8,
    parameter int unsigned dataWidth      = 91,
    parameter int unsigned cent_base_addr = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           cent_cnt,
    output logic                 divider_en,
    input  logic                 divide_by_0,
    input  logic [dataWidth-1:0] new_centroid,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [addrWidth-1:0] mem_addr,
    output logic [dataWidth-1:0] mem_wdata,
    input  logic [dataWidth-1:0] mem_rdata,
    output logic [3:0]           empty_cnt,
    output logic                 converged
);

    localparam int unsigned          WAIT_W    = (div_latency < 1) ? 1 : $clog2(div_latency + 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(div_latency);
    localparam logic [2:0]           IDX_LAST  = 3'(centroid_num - 1);
    localparam logic [addrWidth-1:0] BASE      = addrWidth'(cent_base_addr);

    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2:0]             cent_cnt_q, cent_cnt_d;
    logic                   den_q, den_d;
    logic                   we_q, we_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic [dataWidth-1:0]   wdata_q, wdata_d;
    logic [3:0]             empty_q, empty_d;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
    logic                   re_q, re_d;
    logic [dataWidth-1:0]   old_q, old_d;
    logic                   unch_q, unch_d;
    logic                   conv_q, conv_d;
    logic                   unch_now;
`endif

    // Outputs are registered: every *_d below is the value the output takes
    // in the state being entered, so the divider sample taken on the last
    // CALC cycle lands directly in mem_we/mem_wdata for the WRITE cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cent_cnt_d = cent_cnt_q;
        den_d      = den_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        empty_d    = empty_q;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
        re_d       = 1'b0;
        old_d      = old_q;
        unch_d     = unch_q;
        conv_d     = conv_q;
        unch_now   = unch_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    idx_d      = '0;
                    wait_d     = '0;
                    busy_d     = 1'b1;
                    cent_cnt_d = '0;
                    den_d      = 1'b1;
                    empty_d    = '0;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
                    unch_d     = 1'b1;
                    conv_d     = 1'b0;
                    re_d       = 1'b1;
                    addr_d     = BASE;
`endif
                end
            end
            CALC: begin
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
                // Read data is valid in the cycle after mem_re (second CALC cycle).
                if (wait_q == WAIT_W'(1))
                    old_d = mem_rdata;
`endif
                if (wait_q == WAIT_LAST) begin
                    state_d = WRITE;
                    den_d   = 1'b0;
                    addr_d  = BASE + addrWidth'(idx_q);
                    if (divide_by_0) begin
                        if (empty_q != 4'd15)
                            empty_d = empty_q + 4'd1;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = new_centroid;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WRITE: begin
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
                unch_now = unch_q & ~(we_q && (wdata_q != old_q));
                unch_d   = unch_now;
`endif
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
                    conv_d  = unch_now;
`endif
                end else begin
                    state_d    = CALC;
                    idx_d      = idx_q + 3'd1;
                    cent_cnt_d = idx_q + 3'd1;
                    den_d      = 1'b1;
                    wait_d     = '0;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
                    re_d       = 1'b1;
                    addr_d     = BASE + addrWidth'(idx_q + 3'd1);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cent_cnt_q <= '0;
            den_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            empty_q    <= '0;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
            re_q       <= 1'b0;
            old_q      <= '0;
            unch_q     <= 1'b0;
            conv_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cent_cnt_q <= cent_cnt_d;
            den_q      <= den_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            empty_q    <= empty_d;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
            re_q       <= re_d;
            old_q      <= old_d;
            unch_q     <= unch_d;
            conv_q     <= conv_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cent_cnt   = cent_cnt_q;
    assign divider_en = den_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign empty_cnt  = empty_q;
`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
    assign mem_re     = re_q;
    assign converged  = conv_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_re       = 1'b0;
    assign converged    = 1'b0;
`endif

endmodule

// File: tb/tb_new_means_controller.sv
// Directed bench for new_means_controller with default parameters
// (8 centroids, divider latency 2, base address 0).

module tb_new_means_controller;

`ifdef NEW_MEANS_CONVERGENCE_CHECK_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, divider_en, divide_by_0, mem_we, mem_re, converged;
    logic [2:0]  cent_cnt;
    logic [90:0] new_centroid, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [3:0]  empty_cnt;

    logic [7:0]  skip_mask = '0;
    logic [7:0]  diff_mask = '0;
    logic [2:0]  cnt_d1 = '0, cnt_d2 = '0;
    logic [90:0] rdata_q = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    new_means_controller #(
        .centroid_num(8), .div_latency(2), .addrWidth(8), .dataWidth(91), .cent_base_addr(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cent_cnt(cent_cnt), .divider_en(divider_en), .divide_by_0(divide_by_0),
        .new_centroid(new_centroid), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .empty_cnt(empty_cnt), .converged(converged)
    );

    // Distinct per-index centroid word, all seven 13-bit coordinates differ.
    function automatic logic [90:0] cdata(input int i);
        logic [90:0] v;
        v = '0;
        for (int c = 0; c < 7; c++) v[c*13 +: 13] = 13'(i * 211 + c * 17 + 1);
        return v;
    endfunction

    // Divider model: result reflects cent_cnt from two cycles earlier.
    always @(posedge clk) begin
        cnt_d1 <= cent_cnt;
        cnt_d2 <= cnt_d1;
    end
    assign new_centroid = cdata(int'(cnt_d2));
    assign divide_by_0  = skip_mask[cnt_d2];

    // Centroid memory model: read data one cycle after mem_re.
    always @(posedge clk)
        if (mem_re) rdata_q <= cdata(int'(mem_addr)) ^ (diff_mask[mem_addr[2:0]] ? 91'd1 : 91'd0);
    assign mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cnt"}, cent_cnt, 0);
        check({tag, "_den"}, divider_en, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_re"}, mem_re, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_empty"}, empty_cnt, 0);
        check({tag, "_conv"}, converged, 0);
    endtask

    // Called #1 after a rising edge; start is high for cycle T.
    // Cycle T+k is checked at k = 1..33; extra start pulses at k = s1/s2;
    // abort_k > 0 asserts reset mid-cycle in T+abort_k.
    task automatic run_pass(input logic [7:0] skip, input logic [7:0] diff,
                            input int s1, input int s2, input int abort_k, input logic exp_conv);
        logic ew;
        skip_mask = skip;
        diff_mask = diff;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (k == abort_k) begin
                rst = 1'b1;
                #2;
                check_zero("rst_async");
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check_zero("rst_after");
                end
                return;
            end
            ew = 1'b0;
            if (k % 4 == 0 && k <= 32) ew = !skip[k/4 - 1];
            check("busy", busy, 1);
            check("done", done, k == 33);
            check("we", mem_we, ew);
            if (ew) begin
                check("waddr", mem_addr, k/4 - 1);
                check("wdata", mem_wdata, cdata(k/4 - 1));
            end
            check("div_en", divider_en, (k <= 32) && (k % 4 != 0));
            if (k <= 32 && k % 4 != 0) check("cent_cnt", cent_cnt, (k - 1) / 4);
            check("re", mem_re, CONV_EN && (k <= 32) && (k % 4 == 1));
            if (CONV_EN && k <= 32 && k % 4 == 1) check("raddr", mem_addr, (k - 1) / 4);
            if (k == 1) begin
                check("empty_clr", empty_cnt, 0);
                check("conv_clr", converged, 0);
            end
            if (k == 33) begin
                check("empty", empty_cnt, $countones(skip));
                check("conv", converged, exp_conv & CONV_EN);
            end
            start = (k == s1) || (k == s2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_end", busy, 0);
        check("done_end", done, 0);
        check("empty_hold", empty_cnt, $countones(skip));
        check("conv_hold", converged, exp_conv & CONV_EN);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        #3;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_zero("idle");
        end
        // Full pass, nothing skipped, memory matches -> converged.
        run_pass(8'h00, 8'h00, 0, 0, 0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        // Skip idx 3 and 5, idx 6 differs, stray starts at T+10 and in done cycle.
        run_pass(8'h28, 8'h40, 10, 33, 0, 1'b0);
        // Start one cycle after done: empty_cnt clears, full pass again.
        run_pass(8'h00, 8'h00, 0, 0, 0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        // Reset during CALC of idx 4.
        run_pass(8'h00, 8'h00, 0, 0, 18, 1'b0);
        // Recovery pass rewrites addresses 0..7.
        run_pass(8'h00, 8'h00, 0, 0, 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
